// File: rtl/fifo_frame_writer_pkg.sv
// Shared types and size derivations for the FIFO-to-memory frame writer.
package fifo_frame_writer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  function automatic int unsigned frame_total(input int unsigned width,
                                              input int unsigned height);
    return width * height;
  endfunction

  function automatic int unsigned frame_words(input int unsigned total,
                                              input int unsigned pack);
    return (total + pack - 1) / pack;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_frame_writer_pixel_packer.sv
// Collects PACK pixels into one word; unfilled upper slots always read as zero.
module fifo_frame_writer_pixel_packer #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned PACK   = 4,
  parameter int unsigned CW     = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [DWIDTH-1:0]        pixel,
  output logic [CW-1:0]            pack_cnt,
  output logic [DWIDTH*PACK-1:0]   word,
  output logic                     word_full
);

  localparam logic [CW-1:0] LAST_SLOT = CW'(PACK - 1);

  logic [DWIDTH-1:0] slots [PACK];

  assign word_full = push && (pack_cnt == LAST_SLOT);

  // The word includes the pixel being pushed this cycle so a completing pop
  // can load the output register without an extra cycle.
  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < PACK; i++) begin
      if (CW'(i) < pack_cnt)
        word[i*DWIDTH +: DWIDTH] = slots[i];
      else if (CW'(i) == pack_cnt && push)
        word[i*DWIDTH +: DWIDTH] = pixel;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pack_cnt <= '0;
      slots    <= '{default: '0};
    end else if (clear) begin
      pack_cnt <= '0;
      slots    <= '{default: '0};
    end else if (push) begin
      slots[pack_cnt] <= pixel;
      if (word_full)
        pack_cnt <= '0;
      else
        pack_cnt <= pack_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_frame_writer.sv
// Drains a first-word-fall-through FIFO and writes one packed frame to memory.
module fifo_frame_writer
  import fifo_frame_writer_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 720,
  parameter int unsigned IMG_HEIGHT = 540,
  parameter int unsigned DWIDTH     = 8,
  parameter int unsigned PACK       = 4,
  parameter int unsigned ADDR_WIDTH = 18
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  output logic                    fifo_rd_en,
  input  logic [DWIDTH-1:0]       fifo_dout,
  input  logic                    fifo_empty,
  output logic                    mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DWIDTH*PACK-1:0]  mem_din,
  input  logic                    mem_ready,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int unsigned TOTAL = frame_total(IMG_WIDTH, IMG_HEIGHT);
  localparam int unsigned PW    = cnt_width(TOTAL + 1);
  localparam int unsigned CW    = cnt_width(PACK);
  localparam logic [PW-1:0] LAST_PIX  = PW'(TOTAL - 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(PACK - 1);

  state_t                  state;
  logic [PW-1:0]           pix_cnt;
  logic [CW-1:0]           pack_cnt;
  logic [DWIDTH*PACK-1:0]  word;
  logic                    word_full;
  logic                    out_free;
  logic                    accept;
  logic                    flush_load;
  logic                    load;
  logic                    last_pop;
  logic                    packer_clear;

  always_comb begin
    out_free     = !mem_wr_en || mem_ready;
    accept       = mem_wr_en && mem_ready;
    fifo_rd_en   = (state == RUN) && !fifo_empty &&
                   ((pack_cnt != LAST_SLOT) || out_free);
    flush_load   = (state == FLUSH) && out_free;
    load         = word_full || flush_load;
    last_pop     = fifo_rd_en && (pix_cnt == LAST_PIX);
    packer_clear = ((state == IDLE) && start) || flush_load;
  end

  fifo_frame_writer_pixel_packer #(
    .DWIDTH (DWIDTH),
    .PACK   (PACK),
    .CW     (CW)
  ) u_packer (
    .clock     (clock),
    .reset     (reset),
    .clear     (packer_clear),
    .push      (fifo_rd_en),
    .pixel     (fifo_dout),
    .pack_cnt  (pack_cnt),
    .word      (word),
    .word_full (word_full)
  );

  // mem_addr doubles as the address counter: it always names the word held
  // (or next to be held) in the output register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      pix_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;

      if (load) begin
        mem_din   <= word;
        mem_wr_en <= 1'b1;
      end else if (accept) begin
        mem_wr_en <= 1'b0;
      end

      if ((state == IDLE) && start)
        mem_addr <= base_addr;
      else if (accept)
        mem_addr <= mem_addr + 1'b1;

      if (fifo_rd_en)
        pix_cnt <= pix_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            pix_cnt <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (last_pop) begin
            if (word_full)
              state <= DONE;
            else
              state <= FLUSH;
          end
        end
        FLUSH: begin
          if (out_free)
            state <= DONE;
        end
        DONE: begin
          if (accept) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_frame_writer.sv
// Scoreboard bench: a 4x2 and a 3x3 writer fed from modelled FIFOs.
module tb_fifo_frame_writer;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 8;
  localparam int unsigned PK = 4;

  typedef struct {
    bit              inst;
    logic [AW-1:0]   addr;
    logic [DW*PK-1:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset;

  logic              start      [2];
  logic [AW-1:0]     base_addr  [2];
  logic              fifo_rd_en [2];
  logic [DW-1:0]     fifo_dout  [2];
  logic              fifo_empty [2];
  logic              mem_wr_en  [2];
  logic [AW-1:0]     mem_addr   [2];
  logic [DW*PK-1:0]  mem_din    [2];
  logic              mem_ready  [2];
  logic              busy       [2];
  logic              frame_done [2];

  logic [DW-1:0]     fmem [128];
  int unsigned       fhead [2] = '{0, 0};
  int unsigned       ftail [2];
  logic              gap   [2];

  int                checks;
  int                failures;
  exp_t              exp_q [$];
  logic [DW-1:0]     px [$];
  int unsigned       pop_cnt   [2];
  int unsigned       done_cnt  [2];
  bit                stall_prev[2];
  logic [AW-1:0]     held_addr [2];
  logic [DW*PK-1:0]  held_din  [2];
  bit                ready_rand[2];
  bit                gap_rand  [2];
  logic              ready_lvl [2];
  int unsigned       gap_left  [2];

  always #5 clock = ~clock;

  always_comb begin
    fifo_empty[0] = gap[0] || (fhead[0] == ftail[0]);
    fifo_empty[1] = gap[1] || (fhead[1] == ftail[1]);
    fifo_dout[0]  = fmem[{1'b0, fhead[0][5:0]}];
    fifo_dout[1]  = fmem[{1'b1, fhead[1][5:0]}];
  end

  always @(posedge clock) begin
    if (fifo_rd_en[0]) fhead[0] <= fhead[0] + 1;
    if (fifo_rd_en[1]) fhead[1] <= fhead[1] + 1;
  end

  fifo_frame_writer #(
    .IMG_WIDTH (4), .IMG_HEIGHT (2), .DWIDTH (DW), .PACK (PK), .ADDR_WIDTH (AW)
  ) u0 (
    .clock (clock), .reset (reset), .start (start[0]), .base_addr (base_addr[0]),
    .fifo_rd_en (fifo_rd_en[0]), .fifo_dout (fifo_dout[0]), .fifo_empty (fifo_empty[0]),
    .mem_wr_en (mem_wr_en[0]), .mem_addr (mem_addr[0]), .mem_din (mem_din[0]),
    .mem_ready (mem_ready[0]), .busy (busy[0]), .frame_done (frame_done[0])
  );

  fifo_frame_writer #(
    .IMG_WIDTH (3), .IMG_HEIGHT (3), .DWIDTH (DW), .PACK (PK), .ADDR_WIDTH (AW)
  ) u1 (
    .clock (clock), .reset (reset), .start (start[1]), .base_addr (base_addr[1]),
    .fifo_rd_en (fifo_rd_en[1]), .fifo_dout (fifo_dout[1]), .fifo_empty (fifo_empty[1]),
    .mem_wr_en (mem_wr_en[1]), .mem_addr (mem_addr[1]), .mem_din (mem_din[1]),
    .mem_ready (mem_ready[1]), .busy (busy[1]), .frame_done (frame_done[1])
  );

  function automatic int unsigned tot(input bit i);
    return i ? 9 : 8;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    bit   i;
    forever begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        i = k[0];
        if (reset) begin
          stall_prev[i] = 1'b0;
        end else begin
          if (start[i] && !busy[i]) pop_cnt[i] = 0;
          if (fifo_rd_en[i]) begin
            chk("rd_en_while_empty", 64'(fifo_empty[i]), 64'(0));
            chk("pop_beyond_frame", 64'(pop_cnt[i] >= tot(i)), 64'(0));
            if (pop_cnt[i] % PK == PK - 1)
              chk("complete_while_blocked", 64'(mem_wr_en[i] && !mem_ready[i]), 64'(0));
            pop_cnt[i]++;
          end
          if (stall_prev[i]) begin
            chk("stall_wr_en", 64'(mem_wr_en[i]), 64'(1));
            chk("stall_addr", 64'(mem_addr[i]), 64'(held_addr[i]));
            chk("stall_din", 64'(mem_din[i]), 64'(held_din[i]));
          end
          if (mem_wr_en[i] && mem_ready[i]) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_write inst=%0d actual=0x%0h@0x%0h required=none",
                       i, mem_din[i], mem_addr[i]);
            end else begin
              e = exp_q.pop_front();
              chk("wr_inst", 64'(i), 64'(e.inst));
              chk("wr_addr", 64'(mem_addr[i]), 64'(e.addr));
              chk("wr_data", 64'(mem_din[i]), 64'(e.data));
            end
          end
          stall_prev[i] = mem_wr_en[i] && !mem_ready[i];
          held_addr[i]  = mem_addr[i];
          held_din[i]   = mem_din[i];
          if (frame_done[i]) done_cnt[i]++;
        end
      end
    end
  endtask

  task automatic background();
    bit i;
    forever begin
      @(posedge clock);
      #1;
      for (int k = 0; k < 2; k++) begin
        i = k[0];
        mem_ready[i] = ready_rand[i] ? ($urandom_range(0, 3) != 0) : ready_lvl[i];
        if (gap_left[i] != 0) begin
          gap[i] = 1'b1;
          gap_left[i]--;
        end else if (gap_rand[i] && $urandom_range(0, 2) == 0) begin
          gap[i] = 1'b1;
          gap_left[i] = $urandom_range(0, 4);
        end else begin
          gap[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic load_fifo(input bit i, input int n, input bit rnd);
    logic [DW-1:0] v;
    for (int k = 0; k < n; k++) begin
      v = rnd ? DW'($urandom) : DW'(k + 1);
      fmem[{i, ftail[i][5:0]}] = v;
      ftail[i]++;
      px.push_back(v);
    end
  endtask

  // Reference: word w holds pixels w*PK .. w*PK+PK-1, pixel 0 lowest, zero past the frame end.
  task automatic expect_frame(input bit i, input int base);
    exp_t e;
    int   t;
    int   idx;
    t = int'(tot(i));
    for (int w = 0; w < (t + PK - 1) / PK; w++) begin
      e.inst = i;
      e.addr = AW'(base + w);
      e.data = '0;
      for (int k = 0; k < PK; k++) begin
        idx = w * PK + k;
        if (idx < t) e.data[k*DW +: DW] = px[idx];
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input bit i, input int base);
    base_addr[i] = AW'(base);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input bit i, input int budget);
    int unsigned d0;
    int n;
    d0 = done_cnt[i];
    n = 0;
    while (done_cnt[i] == d0 && n < budget) begin
      tick();
      n++;
    end
    chk("frame_done_seen", 64'(done_cnt[i] != d0), 64'(1));
    repeat (3) tick();
    chk("frame_done_count", 64'(done_cnt[i] - d0), 64'(1));
    chk("busy_idle", 64'(busy[i]), 64'(0));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  task automatic drop(input bit i, input int extra);
    chk("fifo_leftover", 64'(ftail[i] - fhead[i]), 64'(extra));
    ftail[i] = fhead[i];
  endtask

  task automatic rst_check(input bit i);
    chk("rst_outputs", 64'({fifo_rd_en[i], mem_wr_en[i], mem_addr[i], mem_din[i],
                            busy[i], frame_done[i]}), 64'(0));
  endtask

  task automatic run_frame(input bit i, input int base, input int extra, input bit rnd,
                           input int budget);
    px.delete();
    load_fifo(i, int'(tot(i)) + extra, rnd);
    expect_frame(i, base);
    pulse_start(i, base);
    wait_done(i, budget);
    drop(i, extra);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned h0;
    int unsigned d0;
    int n;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0;
      base_addr[k] = '0;
      gap[k] = 1'b0;
      ftail[k] = 0;
      ready_rand[k] = 1'b0;
      gap_rand[k] = 1'b0;
      ready_lvl[k] = 1'b1;
      mem_ready[k] = 1'b1;
      gap_left[k] = 0;
      pop_cnt[k] = 0;
      done_cnt[k] = 0;
      stall_prev[k] = 1'b0;
    end
    fork
      monitor();
      background();
    join_none
    repeat (3) tick();
    rst_check(0);
    rst_check(1);
    reset = 1'b0;
    tick();

    // 4x2 frame, two extra bytes must stay in the FIFO
    run_frame(0, 'h10, 2, 0, 100);

    // output stall for 6 cycles after the first request
    ready_lvl[0] = 1'b0;
    tick();
    px.delete();
    load_fifo(0, 8, 0);
    expect_frame(0, 'h10);
    h0 = fhead[0];
    pulse_start(0, 'h10);
    n = 0;
    while (!mem_wr_en[0] && n < 50) begin
      tick();
      n++;
    end
    chk("first_request_seen", 64'(mem_wr_en[0]), 64'(1));
    repeat (6) tick();
    chk("pops_during_stall", 64'(fhead[0] - h0), 64'(7));
    ready_lvl[0] = 1'b1;
    wait_done(0, 100);
    drop(0, 0);

    // 3x3 frame ends with a zero-filled partial word
    run_frame(1, 'h30, 0, 0, 100);

    // random FIFO gaps
    gap_rand[0] = 1'b1;
    run_frame(0, 'h10, 0, 0, 300);
    gap_rand[0] = 1'b0;
    repeat (8) tick();

    // reset after three pops
    px.delete();
    load_fifo(0, 8, 0);
    h0 = fhead[0];
    pulse_start(0, 'h10);
    n = 0;
    while (fhead[0] - h0 < 3 && n < 50) begin
      tick();
      n++;
    end
    chk("pops_before_reset", 64'(fhead[0] - h0), 64'(3));
    d0 = done_cnt[0];
    reset = 1'b1;
    #1;
    rst_check(0);
    repeat (3) tick();
    chk("no_done_on_abort", 64'(done_cnt[0] - d0), 64'(0));
    reset = 1'b0;
    drop(0, 5);
    tick();
    run_frame(0, 'h20, 0, 1, 100);

    // address wrap with ignored starts during the frame
    px.delete();
    load_fifo(0, 8, 1);
    expect_frame(0, 'h3FFFF);
    pulse_start(0, 'h3FFFF);
    tick();
    pulse_start(0, 'h155);
    tick();
    pulse_start(0, 'h2A);
    wait_done(0, 100);
    drop(0, 0);

    // random frames on both writers with random backpressure and gaps
    for (int r = 0; r < 6; r++) begin
      ready_rand[r[0]] = 1'b1;
      gap_rand[r[0]] = 1'b1;
      run_frame(r[0], int'($urandom_range(0, (1 << AW) - 1)),
                int'($urandom_range(0, 3)), 1, 400);
      ready_rand[r[0]] = 1'b0;
      gap_rand[r[0]] = 1'b0;
      repeat (8) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_frame_writer.md
Name: fifo_frame_writer

Overview:
Drains the pipeline's output FIFO (the read side of the sobel FIFO) and writes one complete frame to a word-addressed memory. Packs PACK consecutive pixels into one memory word and generates addresses from a programmable base. Signals frame completion so the host can reload the pipeline.

Parameters:
IMG_WIDTH, 720, frame width in pixels
IMG_HEIGHT, 540, frame height in pixels
DWIDTH, 8, pixel width (matches the sobel FIFO data width)
PACK, 4, pixels per memory word (>=1)
ADDR_WIDTH, 18, memory word-address width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse that begins a frame; sampled only in IDLE
base_addr  in  ADDR_WIDTH  word address of the first word; latched on start
fifo_rd_en  out  1  pop strobe to the FIFO
fifo_dout  in  DWIDTH  FIFO head data, first-word fall-through (valid while fifo_empty=0)
fifo_empty  in  1  FIFO empty
mem_wr_en  out  1  write request; holds until accepted
mem_addr  out  ADDR_WIDTH  write word address
mem_din  out  DWIDTH*PACK  packed word; pixel 0 in the LSBs
mem_ready  in  1  memory accepts the write in a cycle where mem_wr_en and mem_ready are both 1
busy  out  1  high outside IDLE
frame_done  out  1  one-cycle pulse when the last word is accepted

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0; pixel, pack and address counters 0; pack buffer 0.
- Constants: TOTAL = IMG_WIDTH*IMG_HEIGHT; WORDS = ceil(TOTAL/PACK).
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - On start, latch base_addr into the address counter, clear the counters, go to RUN.
  - start in any other state is ignored.
- RUN, read condition: fifo_rd_en = !fifo_empty && (pack_cnt != PACK-1 || out_free). Combinational; never asserted while fifo_empty=1.
- RUN, pop handling: each pop shifts fifo_dout into slot pack_cnt of the pack buffer and increments pix_cnt.
- RUN, word completion: on the pop where pack_cnt == PACK-1, the completed word loads the output register; mem_wr_en rises the next cycle (1-cycle pop-to-request latency); pack_cnt wraps to 0.
- out_free = !mem_wr_en || mem_ready, so a word accepted this cycle can be replaced back-to-back. Throughput is one word per PACK cycles.
- End of frame:
  - When pix_cnt reaches TOTAL, stop reading.
  - If pack_cnt != 0, go to FLUSH. There, zero-fill the unused upper slots and load the partial word when out_free.
  - Otherwise go to DONE.
- Output register:
  - mem_addr and mem_din stay stable while mem_wr_en=1 && mem_ready=0.
  - On acceptance, the address increments by 1, wrapping mod 2^ADDR_WIDTH.
  - mem_wr_en drops the cycle after acceptance unless a new word loads.
- DONE: wait until the final word is accepted. frame_done pulses high in the cycle after acceptance, then the FSM returns to IDLE.
- Simultaneous acceptance and load in the same cycle: the output register takes the new word, the address advances once, and mem_wr_en stays high.
- No pixels beyond TOTAL are read. Extra FIFO contents remain for the next frame.
- Reset mid-frame: immediate abort to IDLE, no frame_done. FIFO contents are untouched; the system reset is responsible for clearing them.

Decomposition:
- Shared package: state enum (IDLE/RUN/FLUSH/DONE) and the TOTAL/WORDS localparam derivation.
- Sub-module pixel_packer: shift buffer, pack_cnt, zero-fill and word-complete flag.
- The top level keeps the FSM, the pixel and address counters, and the output register/handshake.

Test Plan:
1. IMG 4x2, PACK 4, base 0x10, FIFO pre-filled 0x01..0x08, mem_ready=1:
   - Expect 0x04030201@0x10 then 0x08070605@0x11.
   - Expect one frame_done, then busy=0.
2. Same frame, mem_ready held 0 for 6 cycles after the first request:
   - mem_addr=0x10 and mem_din=0x04030201 stay stable.
   - fifo_rd_en stays low once the second word is complete; no data is lost.
3. IMG 3x3, PACK 4, pixels 0x01..0x09:
   - Expect three words; the last is 0x00000009@base+2 via FLUSH.
4. FIFO empty for random 1-5 cycle gaps mid-frame:
   - fifo_rd_en is never high while fifo_empty=1.
   - Output words are identical to scenario 1.
5. Assert reset after 3 pops in the 4x2 frame:
   - All outputs are 0 immediately and no frame_done.
   - A new start (base 0x20) writes a correct frame at 0x20.
6. start pulses during RUN and with base_addr=2^ADDR_WIDTH-1, 4x2 frame:
   - The start pulses during RUN are ignored.
   - The two words land at 0x3FFFF then wrap to 0x00000.
